// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage core: stage stalls/flushes,
// memory wait freeze with timeout, E-stage forwarding. Optional HAZARD_STATS_EN adds counters.
module hazard_ctrl #(
  parameter int unsigned WARMUP      = 3,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        ResultSrcE0,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushEvents
`endif
);

  typedef enum logic [1:0] {WARM, RUN, MEM_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_mem_err;
  logic        w_err_set;
  logic        w_advance;
  logic        w_load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wr_m, input logic [4:0] rd_m,
                                         input logic       wr_w, input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign w_load_use = ResultSrcE0 && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= WARM;
      r_cnt     <= 16'(WARMUP);
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) r_mem_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_set   = 1'b0;
    w_advance   = 1'b0;
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    case (r_state)
      WARM: begin
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        w_cnt_nxt = r_cnt - 16'd1;
        if (r_cnt == 16'd1) w_state_nxt = RUN;
      end
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
          w_state_nxt = MEM_WAIT;
          w_cnt_nxt   = 16'(MEM_TIMEOUT);
        end else begin
          w_advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Timeout releases the freeze exactly like an ack, but latches the error.
        if (MemReadyM || r_cnt == 16'd1) begin
          w_advance   = 1'b1;
          w_err_set   = !MemReadyM;
          w_state_nxt = RUN;
        end else begin
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = WARM;
        w_cnt_nxt   = 16'(WARMUP);
      end
    endcase
    // A taken branch squashes the dependent instruction, so it overrides load-use.
    if (w_advance) begin
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign ForwardAE = reset ? fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW) : 2'b00;
  assign ForwardBE = reset ? fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW) : 2'b00;
  assign MemErr    = r_mem_err;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
    end else begin
      if (StallF && r_stall_cycles != 32'hFFFF_FFFF)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (FlushE && r_state != WARM && r_flush_events != 32'hFFFF_FFFF)
        r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign StallCycles = r_stall_cycles;
  assign FlushEvents = r_flush_events;
`endif

endmodule
